systolic_a_feeder: RTL and testbench

- Input stage that sits directly upstream of the tpumac array and drives the A operand into the west edge of a DIM x DIM systolic grid.
- Holds one DIM x DIM signed matrix A, written one row per cycle by the host/loader.
- On start, streams A into the array with diagonal skew: lane i is delayed i cycles, so every product A[i][k]*B[k][j] meets its partner in the grid.
- Also generates the shared MAC enable and a completion pulse.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/systolic_a_feeder.sv | 149 ++++++++++++++
 tb/tb_systolic_a_feeder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath: operand sizing, the feeder
// state encoding and the packed row type used by the loader.
package tpu_pkg;

  localparam int BITS_AB      = 8;
  localparam int DIM          = 8;
  localparam int STREAM_BEATS = 2 * DIM - 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef logic [DIM*BITS_AB-1:0] row_t;

  // Width of a counter able to hold beat indices 0 .. 2*dim-2.
  function automatic int beat_width(input int dim);
    return $clog2(2 * dim - 1);
  endfunction

endpackage

// File: rtl/systolic_a_feeder.sv
// West-edge A-operand feeder for a DIM x DIM systolic array.
// Holds matrix A (one row written per cycle) and, on start, streams it
// into the array with a diagonal skew of one cycle per lane. Every output
// comes straight from a flop; the next-output logic looks at next state
// and next storage so a row written on the start edge is already visible.
module systolic_a_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int DIM     = tpu_pkg::DIM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DIM)-1:0]     wr_row,
  input  logic [DIM*BITS_AB-1:0]     wr_data,
  input  logic                       start,
  output logic [DIM*BITS_AB-1:0]     a_out,
  output logic                       mac_en,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = beat_width(DIM);
  localparam int KW = $clog2(DIM);
  localparam logic [CW-1:0] LAST_BEAT = CW'(2 * DIM - 2);
  localparam logic [CW-1:0] KMAX      = CW'(DIM - 1);

  state_e                               state_q, state_d;
  logic [CW-1:0]                        beat_q, beat_d;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] mem_q, mem_d;
  logic                                 wr_ok_s;
  logic                                 stream_d;
  wire  [DIM*BITS_AB-1:0]               a_out_d;
  logic [DIM*BITS_AB-1:0]               a_out_q;
  logic                                 mac_en_q, mac_en_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  // Writes are accepted only while idle and only for an existing row.
  always_comb begin
    wr_ok_s = 1'b0;
    if ((state_q == IDLE) && wr_en && (int'(wr_row) < DIM)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Next storage contents: overwrite the addressed row on an accepted write.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok_s) begin
      mem_d[wr_row] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Next-state and beat counter; the counter restarts at 0 on every pass.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (start) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          state_d = STREAM;
          beat_d  = beat_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Control outputs for the beat that the next cycle will present.
  always_comb begin
    stream_d = (state_d == STREAM);
    mac_en_d = stream_d;
    busy_d   = stream_d;
    if (stream_d && (beat_d == LAST_BEAT)) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Per-lane skewed select: lane i shows A[i][t-i] inside its window, else 0.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    localparam logic [CW-1:0] LO = CW'(gi);

    logic [CW:0]         diff_s;
    logic [KW-1:0]       k_s;
    logic [BITS_AB-1:0]  val_s;

    // Element index for this lane and the zero fill outside its window.
    always_comb begin
      diff_s = {1'b0, beat_d} - {1'b0, LO};
      k_s    = KW'(diff_s[CW-1:0]);
      if (stream_d && !diff_s[CW] && (diff_s[CW-1:0] <= KMAX)) begin
        val_s = mem_d[gi][k_s];
      end else begin
        val_s = '0;
      end
    end

    assign a_out_d[gi*BITS_AB +: BITS_AB] = val_s;
  end

  // State, storage and output registers; reset abandons any pass at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      mem_q    <= '0;
      a_out_q  <= '0;
      mac_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      mem_q    <= mem_d;
      a_out_q  <= a_out_d;
      mac_en_q <= mac_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign a_out  = a_out_q;
  assign mac_en = mac_en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_systolic_a_feeder.sv
// Directed self-checking bench for systolic_a_feeder (DIM=8, BITS_AB=8).
module tb_systolic_a_feeder;

  localparam int BITS = 8;
  localparam int N    = 8;
  localparam int W    = N * BITS;
  localparam int BEATS = 2 * N - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_row = 3'd0;
  logic [W-1:0]   wr_data = '0;
  logic           start = 1'b0;
  logic [W-1:0]   a_out;
  logic           mac_en;
  logic           busy;
  logic           done;

  logic [7:0]     model [N][N];
  int             n_checks = 0;
  int             n_fail = 0;

  systolic_a_feeder #(.BITS_AB(BITS), .DIM(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
    .a_out   (a_out),
    .mac_en  (mac_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] exp_vec(input int t);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if ((t - i >= 0) && (t - i <= N - 1)) v[i*BITS +: BITS] = model[i][t-i];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] fill_row(input logic [7:0] b);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*BITS +: BITS] = b;
    return v;
  endfunction

  task automatic write_row(input int r, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_row  = 3'(r);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Checks a whole pass starting at beat 0; optionally pokes a write at wr_beat.
  task automatic check_pass(input int pid, input int wr_beat);
    int on_cnt;
    logic [W-1:0] lanes;
    on_cnt = 0;
    for (int t = 0; t < BEATS; t++) begin
      lanes = a_out;
      check($sformatf("p%0d a_out t=%0d", pid, t), lanes, exp_vec(t));
      check($sformatf("p%0d busy t=%0d", pid, t), W'(busy), W'(1'b1));
      check($sformatf("p%0d done t=%0d", pid, t), W'(done), W'(t == BEATS - 1));
      if (mac_en) on_cnt++;
      if (pid == 1 && t == 0) check("p1 lane0 t0", W'(lanes[7:0]), W'(8'd1));
      if (pid == 1 && t == 7) begin
        check("p1 lane0 t7", W'(lanes[7:0]), W'(8'd8));
        check("p1 lane7 t7", W'(lanes[63:56]), W'(8'd57));
      end
      if (pid == 1 && t == 14) begin
        check("p1 lane7 t14", W'(lanes[63:56]), W'(8'd64));
        check("p1 lanes0-6 t14", W'(lanes[55:0]), W'(56'd0));
      end
      if (t == wr_beat) begin
        wr_en = 1'b1; wr_row = 3'd0; wr_data = fill_row(8'hFF);
      end
      tick();
      if (t == wr_beat) wr_en = 1'b0;
    end
    if (mac_en) on_cnt++;
    check($sformatf("p%0d mac_en cycles", pid), W'(on_cnt), W'(BEATS));
    check($sformatf("p%0d idle a_out", pid), a_out, '0);
    check($sformatf("p%0d idle busy", pid), W'(busy), W'(1'b0));
    check($sformatf("p%0d idle done", pid), W'(done), W'(1'b0));
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) model[i][k] = 8'(8 * i + k + 1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst a_out", a_out, '0);
    check("rst mac_en", W'(mac_en), W'(1'b0));
    check("rst busy", W'(busy), W'(1'b0));
    check("rst done", W'(done), W'(1'b0));
    rst = 1'b0;
    tick();

    // Load A[i][k] = 8i+k+1 and run a plain pass
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] d;
      for (int k = 0; k < N; k++) d[k*BITS +: BITS] = model[i][k];
      write_row(i, d);
    end
    check("idle before start", a_out, '0);
    start = 1'b1; tick(); start = 1'b0;
    check_pass(1, -1);

    // Negative values on row 2
    write_row(2, fill_row(8'h80));
    for (int k = 0; k < N; k++) model[2][k] = 8'h80;
    start = 1'b1; tick(); start = 1'b0;
    check_pass(2, -1);

    // Write during beat 4 must be ignored
    start = 1'b1; tick(); start = 1'b0;
    check_pass(3, 4);
    start = 1'b1; tick(); start = 1'b0;
    check_pass(4, -1);
    check("row0 kept lane0 idle", a_out, '0);

    // Same-cycle write of row 5 and start
    wr_en = 1'b1; wr_row = 3'd5; wr_data = fill_row(8'h11); start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    for (int k = 0; k < N; k++) model[5][k] = 8'h11;
    check_pass(5, -1);

    // start held high: back-to-back passes with a one-cycle idle gap
    start = 1'b1;
    tick();
    check_pass(6, -1);
    tick();
    check_pass(7, -1);
    start = 1'b0;
    tick();
    check("after held idle busy", W'(busy), W'(1'b0));

    // Reset in the middle of a pass
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("mid beat3 a_out", a_out, exp_vec(3));
    #1 rst = 1'b1;
    #1;
    check("mid rst a_out", a_out, '0);
    check("mid rst mac_en", W'(mac_en), W'(1'b0));
    check("mid rst busy", W'(busy), W'(1'b0));
    check("mid rst done", W'(done), W'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post rst done c=%0d", c), W'(done), W'(1'b0));
      check($sformatf("post rst busy c=%0d", c), W'(busy), W'(1'b0));
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) model[i][k] = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    check_pass(8, -1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
